// File: rtl/fft_job_scheduler_pkg.sv
// Shared FFT scheduler definitions: engine run length, requester count,
// scheduler state encoding and the latched job context.
package fft_job_scheduler_pkg;

  // 6 radix-2 stages x 32 butterflies per transform.
  localparam int unsigned FFT_RUN_CYCLES = 192;
  localparam int unsigned FFT_N_REQ      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;

  // Job context captured at accept and held for the life of the job.
  typedef struct packed {
    logic owner;
    logic ifft;
  } job_ctx_t;

  // One-hot encoding of a 1-bit requester index.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fft_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst   : falling-edge clock, async active-low reset
//   req[1:0]   : requests (already qualified by the caller)
//   advance    : grant was taken; remember the winner
//   grant[1:0] : one-hot grant, zero when no request
//   idx        : index of the winner (valid when grant != 0)
module rr_arbiter2
  import fft_job_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       idx
);

  // Index granted last; reset to 1 so requester 0 wins first contention.
  logic r_last;

  // Winner select: on contention the one not granted last.
  always_comb begin
    idx   = 1'b0;
    grant = 2'b00;
    if (req == 2'b11) begin
      idx = ~r_last;
    end else begin
      idx = req[1];
    end
    if (req != 2'b00) begin
      grant = owner_onehot(idx);
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (advance) begin
      r_last <= idx;
    end
  end

endmodule

// File: rtl/fft_job_scheduler.sv
// Shares one FFT engine between two requesters: round-robin grant,
// one-cycle engine start, fixed-length run count, result hold until the
// owner acknowledges.
// Ports:
//   clk        : clock, all state on the falling edge (engine timing)
//   rst        : async active-low reset
//   req_valid  : per-requester job request
//   req_ifft   : per-requester inverse flag, sampled at grant
//   req_ready  : one-hot grant (combinational, IDLE only)
//   rsp_valid  : one-hot result-ready to the owner
//   rsp_ready  : per-requester result acknowledgement
//   fft_start  : engine start pulse
//   fft_ifft   : engine inverse select
//   fft_sel    : owner index, steers the data muxes
//   busy       : scheduler not idle
module fft_job_scheduler
  import fft_job_scheduler_pkg::*;
#(
  parameter int unsigned RUN_CYCLES = FFT_RUN_CYCLES,
  parameter int unsigned N_REQ      = FFT_N_REQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_ifft,
  output logic [N_REQ-1:0] req_ready,
  output logic [N_REQ-1:0] rsp_valid,
  input  logic [N_REQ-1:0] rsp_ready,
  output logic             fft_start,
  output logic             fft_ifft,
  output logic             fft_sel,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RUN_CYCLES - 1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  job_ctx_t         r_ctx;
  logic             r_fft_start;
  logic             r_busy;
  logic [N_REQ-1:0] r_rsp_valid;

  logic [N_REQ-1:0] w_arb_req;
  logic [N_REQ-1:0] w_grant;
  logic             w_grant_idx;
  logic             w_accept;
  logic             w_owner_ack;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign w_arb_req   = (rst && (r_state == ST_IDLE)) ? req_valid : '0;
  assign w_accept    = |w_grant;
  assign w_owner_ack = rsp_ready[r_ctx.owner];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_arb_req),
    .advance (w_accept),
    .grant   (w_grant),
    .idx     (w_grant_idx)
  );

  // State register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_state_nxt = ST_LOAD;
      ST_LOAD:                     w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == '0)    w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_owner_ack)    w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Run counter: loaded on entry to RUN, stops at zero, zero elsewhere.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Job context captured at accept; held until the next accept.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_ctx <= '0;
    end else if (w_accept) begin
      r_ctx.owner <= w_grant_idx;
      r_ctx.ifft  <= req_ifft[w_grant_idx];
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_fft_start <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      r_fft_start <= (w_state_nxt == ST_LOAD);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_HOLD) ? owner_onehot(r_ctx.owner) : '0;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign fft_start = r_fft_start;
  assign busy      = r_busy;
  assign fft_sel   = r_ctx.owner;
  assign fft_ifft  = r_ctx.ifft;

endmodule
